// File: rtl/seg7_pkg.sv
// Shared types, constants and the BCD-to-segment encoder for the latched 7-seg bus driver.
// Defining SEG7_DP_EN widens every pattern by one trailing decimal-point bit.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } seg7_state_t;

    localparam int SEG_BITS = 7;
`ifdef SEG7_DP_EN
    localparam int SEG_W = SEG_BITS + 1;
`else
    localparam int SEG_W = SEG_BITS;
`endif

    localparam logic [SEG_BITS-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [SEG_BITS-1:0] SEG_DASH  = 7'b0000001;

    // Active-high {a,b,c,d,e,f,g}; non-decimal codes show a dash.
    function automatic logic [SEG_BITS-1:0] seg7_encode(input logic [3:0] bcd, input logic blank);
        logic [SEG_BITS-1:0] pat;
        if (blank) begin
            pat = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    pat = 7'b1111110;
                4'd1:    pat = 7'b0110000;
                4'd2:    pat = 7'b1101101;
                4'd3:    pat = 7'b1111001;
                4'd4:    pat = 7'b0110011;
                4'd5:    pat = 7'b1011011;
                4'd6:    pat = 7'b1011111;
                4'd7:    pat = 7'b1110000;
                4'd8:    pat = 7'b1111111;
                4'd9:    pat = 7'b1111011;
                default: pat = SEG_DASH;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_latched_bus_n_if.sv
// Display-side signal bundle: BCD source drives the master side, the driver is the slave.
// dp_in exists only when SEG7_DP_EN is defined.
interface seg7_latched_bus_n_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic                      lz_blank;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]     dp_in;
`endif
    logic [seg7_pkg::SEG_W-1:0] seg7_bus;
    logic [NUM_DIGITS-1:0]     le;
    logic                      busy;

`ifdef SEG7_DP_EN
    modport master (output bcd_in, lz_blank, dp_in, input seg7_bus, le, busy);
    modport slave  (input bcd_in, lz_blank, dp_in, output seg7_bus, le, busy);
`else
    modport master (output bcd_in, lz_blank, input seg7_bus, le, busy);
    modport slave  (input bcd_in, lz_blank, output seg7_bus, le, busy);
`endif
endinterface

// File: rtl/seg7_lz_blanker.sv
// Leading-zero blank vector: digit k (k >= 1) blanks when it and every digit above it is zero.
module seg7_lz_blanker #(
    parameter int NUM_DIGITS = 6
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   blank
);
    // zero_up[k]: digit k and all more significant digits are zero
    logic [NUM_DIGITS-1:1] zero_up;

    assign zero_up[NUM_DIGITS-1] = (bcd_in[4*NUM_DIGITS-1 -: 4] == 4'd0);

    generate
        for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_zero
            assign zero_up[gi] = zero_up[gi+1] && (bcd_in[4*gi +: 4] == 4'd0);
        end
    endgenerate

    assign blank = {zero_up & {(NUM_DIGITS-1){lz_blank}}, 1'b0};
endmodule

// File: rtl/seg7_latched_bus_n.sv
// N-digit latched 7-seg driver: rewrites only changed digits over one shared bus, round-robin,
// with periodic forced refresh. Optional decimal points via SEG7_DP_EN.
module seg7_latched_bus_n
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int LE_ACTIVE_HIGH = 1,
    parameter int LE_WIDTH_TICKS = 1,
    parameter int REFRESH_PERIOD = 64
) (
    input  logic                clk_ac,
    input  logic                rst,
    seg7_latched_bus_n_if.slave disp
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    seg7_state_t           state_reg;
    logic [IDX_W-1:0]      ptr_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      sel_idx;
    logic [SEG_W-1:0]      bus_reg;
    logic [SEG_W-1:0]      shadow_reg [NUM_DIGITS];
    logic [SEG_W-1:0]      pat_cur    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] force_reg;
    logic [NUM_DIGITS-1:0] force_next;
    logic [NUM_DIGITS-1:0] le_reg;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] dirty;
    logic [3:0]            strobe_cnt_reg;
    logic                  busy_reg;
    logic                  found;
    logic                  refresh_tick;

    seg7_lz_blanker #(.NUM_DIGITS(NUM_DIGITS)) u_blanker (
        .bcd_in   (disp.bcd_in),
        .lz_blank (disp.lz_blank),
        .blank    (blank)
    );

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
`ifdef SEG7_DP_EN
            assign pat_cur[gi] = {seg7_encode(disp.bcd_in[4*gi +: 4], blank[gi]),
                                  disp.dp_in[gi] & ~blank[gi]};
`else
            assign pat_cur[gi] = seg7_encode(disp.bcd_in[4*gi +: 4], blank[gi]);
`endif
            assign dirty[gi] = (pat_cur[gi] != shadow_reg[gi]) || force_reg[gi];
        end

        if (REFRESH_PERIOD > 0) begin : g_refresh
            localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [RW-1:0] refresh_cnt_reg;
            assign refresh_tick = (refresh_cnt_reg == RW'(REFRESH_PERIOD - 1));
            always_ff @(posedge clk_ac) begin
                if (rst || refresh_tick) refresh_cnt_reg <= '0;
                else                     refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
            end
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    // First dirty digit at or after the scan pointer, wrapping.
    always_comb begin
        logic [IDX_W:0] cand;
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_DIGITS)) cand = cand - (IDX_W+1)'(NUM_DIGITS);
            if (!found && dirty[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IDX_W-1:0];
            end
        end
    end

    // The force flag drops at capture, so a refresh landing any time during the write
    // (including the capture tick itself) leaves the digit queued for another pass.
    always_comb begin
        force_next = force_reg;
        if (state_reg == ST_IDLE && found) force_next[sel_idx] = 1'b0;
        if (refresh_tick)                  force_next = '1;
    end

    always_ff @(posedge clk_ac) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            idx_reg        <= '0;
            bus_reg        <= '0;
            le_reg         <= '0;
            busy_reg       <= 1'b0;
            strobe_cnt_reg <= '0;
            force_reg      <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) shadow_reg[i] <= '0;
        end else begin
            force_reg <= force_next;
            case (state_reg)
                ST_IDLE: begin
                    if (found) begin
                        idx_reg   <= sel_idx;
                        bus_reg   <= pat_cur[sel_idx];
                        busy_reg  <= 1'b1;
                        state_reg <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    le_reg         <= NUM_DIGITS'(1) << idx_reg;
                    strobe_cnt_reg <= '0;
                    state_reg      <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (strobe_cnt_reg == 4'(LE_WIDTH_TICKS - 1)) begin
                        le_reg              <= '0;
                        shadow_reg[idx_reg] <= bus_reg;
                        state_reg           <= ST_HOLD;
                    end else begin
                        strobe_cnt_reg <= strobe_cnt_reg + 4'd1;
                    end
                end
                ST_HOLD: begin
                    ptr_reg   <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign disp.seg7_bus = (SEG_ACTIVE_LOW != 0) ? ~bus_reg : bus_reg;
    assign disp.le       = (LE_ACTIVE_HIGH != 0) ? le_reg  : ~le_reg;
    assign disp.busy     = busy_reg;
endmodule
